// File: rtl/read_operation_ctrl_pkg.sv
// Shared sizes and FSM state encodings for the register-file read controller.
package read_operation_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SELECT = 2'b01,
        VALID  = 2'b10
    } state_t;

endpackage

// File: rtl/read_operation_ctrl_mux.sv
// Combinational 8-to-1 word selector over the flattened register-file bus.
module _8_to_1_mux
    import read_operation_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [NREG*WIDTH-1:0] data_in,
    input  logic [ADDR_W-1:0]     sel,
    output logic [WIDTH-1:0]      data_out
);

    logic [WIDTH-1:0] words [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_split
        assign words[i] = data_in[i*WIDTH +: WIDTH];
    end

    assign data_out = words[sel];

endmodule

// File: rtl/read_operation_ctrl.sv
// Read-side controller: accepts a read, snapshots the addressed register
// (with same-cycle write bypass) and holds the result until handshaken.
module read_operation_ctrl
    import read_operation_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic [NREG*DATA_W-1:0]   from_reg,
    input  logic [NREG-1:0]          wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     busy,
    output logic [7:0]               rd_count
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   mux_data;
    logic [DATA_W-1:0]   sel_data;

    _8_to_1_mux #(
        .WIDTH (DATA_W)
    ) u_mux (
        .data_in  (from_reg),
        .sel      (addr_q),
        .data_out (mux_data)
    );

    // A write landing on the selected register in the SELECT cycle wins over the stale file contents.
    assign sel_data = wr_en[addr_q] ? wr_data : mux_data;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            rd_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (re) begin
                        addr_q <= Addr;
                        state  <= SELECT;
                    end
                end
                SELECT: begin
                    rd_data  <= sel_data;
                    rd_addr  <= addr_q;
                    rd_valid <= 1'b1;
                    state    <= VALID;
                end
                VALID: begin
                    // Result is a snapshot: only a handshake releases it, and re chains the next read.
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_count <= rd_count + 8'd1;
                        if (re) begin
                            addr_q <= Addr;
                            state  <= SELECT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_operation_ctrl.sv
// Self-checking bench: directed scenarios then randomized reads against a
// transaction-level model of the read controller.
module tb_read_operation_ctrl;

    logic          clk;
    logic          reset;
    logic          re;
    logic [2:0]    Addr;
    logic [255:0]  from_reg;
    logic [7:0]    wr_en;
    logic [31:0]   wr_data;
    logic          rd_ready;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic [2:0]    rd_addr;
    logic          busy;
    logic [7:0]    rd_count;

    int            total;
    int            bad;
    int            exp_count;
    logic [31:0]   exp_data;

    read_operation_ctrl #(
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .re       (re),
        .Addr     (Addr),
        .from_reg (from_reg),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scrambles the register file and write side; optionally forces a write onto word a.
    task automatic apply_stimulus(input bit hit, input logic [2:0] a);
        for (int k = 0; k < 8; k++) from_reg[k*32 +: 32] = $urandom;
        wr_en   = 8'($urandom);
        wr_en[a] = hit;
        wr_data = $urandom;
    endtask

    task automatic issue_read(input logic [2:0] a);
        re       = 1'b1;
        Addr     = a;
        rd_ready = 1'($urandom);
        tick;
        re = 1'b0;
    endtask

    // Entered in the SELECT cycle of a read of address a; finishes with a handshake.
    task automatic read_body(input logic [2:0] a, input int stall, input bit b2b, input logic [2:0] next_a);
        apply_stimulus(1'($urandom), a);
        re       = 1'($urandom);
        Addr     = 3'($urandom);
        rd_ready = 1'($urandom);
        exp_data = wr_en[a] ? wr_data : from_reg[a*32 +: 32];
        check_output("select_busy", busy, 1'b1);
        check_output("select_valid", rd_valid, 1'b0);
        tick;
        check_output("result_valid", rd_valid, 1'b1);
        check_output("result_data", rd_data, exp_data);
        check_output("result_addr", rd_addr, a);
        for (int s = 0; s < stall; s++) begin
            rd_ready = 1'b0;
            re       = 1'($urandom);
            Addr     = 3'($urandom);
            apply_stimulus(1'b1, a);
            tick;
            check_output("stall_valid", rd_valid, 1'b1);
            check_output("stall_data", rd_data, exp_data);
            check_output("stall_count", rd_count, exp_count);
        end
        rd_ready = 1'b1;
        re       = b2b;
        Addr     = next_a;
        tick;
        exp_count = (exp_count + 1) % 256;
        rd_ready  = 1'b0;
        re        = 1'b0;
        check_output("hs_valid", rd_valid, 1'b0);
        check_output("hs_count", rd_count, exp_count);
        check_output("hs_busy", busy, b2b);
    endtask

    initial begin
        logic [2:0] cur_a;
        logic [2:0] nxt_a;
        bit         chained;
        bit         nxt_chain;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        re = 1'b0; Addr = '0; from_reg = '0; wr_en = '0; wr_data = '0; rd_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        check_output("rst_valid", rd_valid, 1'b0);
        check_output("rst_data", rd_data, 32'h0);
        check_output("rst_addr", rd_addr, 3'd0);
        check_output("rst_count", rd_count, 8'd0);
        check_output("rst_busy", busy, 1'b0);

        // Basic read of register 5
        from_reg[5*32 +: 32] = 32'hA5A5_0005;
        re = 1'b1; Addr = 3'd5;
        tick;
        re = 1'b0;
        check_output("basic_c1_valid", rd_valid, 1'b0);
        tick;
        check_output("basic_valid", rd_valid, 1'b1);
        check_output("basic_data", rd_data, 32'hA5A5_0005);
        check_output("basic_addr", rd_addr, 3'd5);
        rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
        check_output("basic_idle", busy, 1'b0);
        check_output("basic_count", rd_count, 8'd1);

        // Same-cycle write bypass on register 3
        re = 1'b1; Addr = 3'd3;
        tick;
        re = 1'b0; wr_en = 8'b0000_1000; wr_data = 32'hDEAD_BEEF;
        tick;
        wr_en = '0;
        check_output("bypass_data", rd_data, 32'hDEAD_BEEF);
        rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;

        // Backpressure with register 2 rewritten during the stall
        from_reg[2*32 +: 32] = 32'h1234_5678;
        re = 1'b1; Addr = 3'd2;
        tick;
        re = 1'b0;
        tick;
        check_output("bp_data0", rd_data, 32'h1234_5678);
        for (int s = 0; s < 5; s++) begin
            wr_en = 8'b0000_0100; wr_data = $urandom;
            from_reg[2*32 +: 32] = $urandom;
            re = 1'b1; Addr = 3'($urandom);
            tick;
            check_output("bp_valid", rd_valid, 1'b1);
            check_output("bp_data", rd_data, 32'h1234_5678);
            check_output("bp_addr", rd_addr, 3'd2);
        end
        re = 1'b0; wr_en = '0; rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
        check_output("bp_count", rd_count, 8'd3);
        check_output("bp_idle", busy, 1'b0);

        // Reset while holding a result
        re = 1'b1; Addr = 3'd6;
        tick;
        re = 1'b0;
        tick;
        check_output("mid_valid", rd_valid, 1'b1);
        reset = 1'b1; rd_ready = 1'b1;
        tick;
        reset = 1'b0; rd_ready = 1'b0;
        check_output("mid_rst_valid", rd_valid, 1'b0);
        check_output("mid_rst_data", rd_data, 32'h0);
        check_output("mid_rst_count", rd_count, 8'd0);
        check_output("mid_rst_busy", busy, 1'b0);
        from_reg[1*32 +: 32] = 32'h0000_0011;
        re = 1'b1; Addr = 3'd1;
        tick;
        re = 1'b0;
        check_output("post_rst_accept", busy, 1'b1);
        tick;
        check_output("post_rst_data", rd_data, 32'h0000_0011);
        check_output("post_rst_addr", rd_addr, 3'd1);

        // Randomized reads, mixing idle gaps and back-to-back chaining
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_count = 0;
        chained = 1'b0;
        cur_a = 3'($urandom);
        for (int i = 0; i < 300; i++) begin
            if (!chained) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    rd_ready = 1'($urandom);
                    tick;
                    check_output("idle_count", rd_count, exp_count);
                    check_output("idle_valid", rd_valid, 1'b0);
                end
                issue_read(cur_a);
            end
            nxt_a     = 3'($urandom);
            nxt_chain = (i < 299) ? 1'($urandom) : 1'b0;
            read_body(cur_a, int'($urandom_range(0, 3)), nxt_chain, nxt_a);
            cur_a   = nxt_a;
            chained = nxt_chain;
        end
        check_output("wrap_count", rd_count, 8'd44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
